// File: rtl/dpd_pkg.sv
// Shared types and helpers for the densely-packed-decimal decode path.
package dpd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam int DECL_W = 10;
  localparam int BCD3_W = 12;

  // Digits 8/9 in every position ignore p,q; a set p or q there is a redundant code.
  function automatic logic is_noncanon(input logic [9:0] dpd);
    return (dpd[6:5] == 2'b11) && (dpd[3:1] == 3'b111) && (dpd[9:8] != 2'b00);
  endfunction

endpackage

// File: rtl/dpd_unpack.sv
// Combinational decode of one 10-bit DPD declet into three BCD digits.
module dpd_unpack (
  input  logic [9:0]  dpd,
  output logic [11:0] bcd
);

  logic p, q, r, s, t, u, v, w, x, y;
  logic [3:0] d2, d1, d0;

  assign {p, q, r, s, t, u, v, w, x, y} = dpd;
  assign bcd = {d2, d1, d0};

  always_comb begin
    d2 = {1'b0, p, q, r};
    d1 = {1'b0, s, t, u};
    d0 = {1'b0, w, x, y};
    if (v) begin
      unique case ({w, x})
        2'b00: d0 = {3'b100, y};
        2'b01: begin
          d1 = {3'b100, u};
          d0 = {1'b0, s, t, y};
        end
        2'b10: begin
          d2 = {3'b100, r};
          d0 = {1'b0, p, q, y};
        end
        default: begin
          unique case ({s, t})
            2'b00: begin
              d2 = {3'b100, r};
              d1 = {3'b100, u};
              d0 = {1'b0, p, q, y};
            end
            2'b01: begin
              d2 = {3'b100, r};
              d1 = {1'b0, p, q, u};
              d0 = {3'b100, y};
            end
            2'b10: begin
              d1 = {3'b100, u};
              d0 = {3'b100, y};
            end
            default: begin
              d2 = {3'b100, r};
              d1 = {3'b100, u};
              d0 = {3'b100, y};
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: rtl/dpd_seq_unpack.sv
// Sequential multi-declet DPD to BCD converter sharing one dpd_unpack datapath.
module dpd_seq_unpack #(
  parameter  int NDECL = 5,
  localparam int NDW   = $clog2(3 * NDECL + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [10*NDECL-1:0] in_dpd,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [12*NDECL-1:0] out_bcd,
  output logic [NDW-1:0]      out_ndig,
  output logic                out_noncanon
);

  import dpd_pkg::*;

  localparam int IDXW = (NDECL > 1) ? $clog2(NDECL) : 1;

  state_t              state;
  logic [10*NDECL-1:0] shreg;
  logic [IDXW-1:0]     idx;
  logic [11:0]         dig;
  logic [NDW-1:0]      idx3;

  dpd_unpack u_unpack (
    .dpd (shreg[DECL_W-1:0]),
    .bcd (dig)
  );

  assign idx3 = NDW'(idx) * NDW'(3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      shreg        <= '0;
      idx          <= '0;
      out_bcd      <= '0;
      out_ndig     <= NDW'(1);
      out_noncanon <= 1'b0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            shreg        <= in_dpd;
            idx          <= '0;
            out_bcd      <= '0;
            out_ndig     <= NDW'(1);
            out_noncanon <= 1'b0;
            in_ready     <= 1'b0;
            state        <= BUSY;
          end
        end
        BUSY: begin
          // Digit group lands at the slot picked by idx; out_bcd itself never shifts.
          for (int unsigned k = 0; k < NDECL; k++) begin
            if (idx == IDXW'(k)) out_bcd[k*BCD3_W +: BCD3_W] <= dig;
          end
          shreg <= shreg >> DECL_W;
          if (dig[11:8] != 4'd0)     out_ndig <= idx3 + NDW'(3);
          else if (dig[7:4] != 4'd0) out_ndig <= idx3 + NDW'(2);
          else if (dig[3:0] != 4'd0) out_ndig <= idx3 + NDW'(1);
          if (is_noncanon(shreg[DECL_W-1:0])) out_noncanon <= 1'b1;
          if (idx == IDXW'(NDECL - 1)) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
